// File: rtl/multiport_mem_model.sv
// Byte-addressed little-endian memory: NUM_RD word read ports, a word write port and a byte-enabled data port.
// Define MULTIPORT_MEM_MODEL_ALIGN_CHECK_EN to trap accesses whose address is not word aligned.
module multiport_mem_model #(
    parameter int MEM_SIZE   = 512,
    parameter int NUM_RD     = 3,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_RD-1:0]    rd_en,
    input  logic [NUM_RD*32-1:0] rd_addr,
    output logic [NUM_RD*32-1:0] rd_data,
    output logic [NUM_RD-1:0]    rd_valid,
    input  logic                 wp_en,
    input  logic [31:0]          wp_addr,
    input  logic [31:0]          wp_data,
    input  logic                 dm_rd,
    input  logic                 dm_wr,
    input  logic [31:0]          dm_addr,
    input  logic [31:0]          dm_wdata,
    input  logic [3:0]           dm_be,
    output logic [31:0]          dm_rdata,
    output logic                 dm_rvalid,
    output logic                 err_conflict,
    output logic                 err_oob,
    output logic                 err_misalign,
    input  logic                 err_clr
);
`ifdef MULTIPORT_MEM_MODEL_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif
    localparam int AW = (MEM_SIZE > 2) ? $clog2(MEM_SIZE) : 1;
    localparam int NP = NUM_RD + 1;  // lane NUM_RD carries the dm read
    localparam int L  = RD_LATENCY;

    logic [7:0] mem [MEM_SIZE];

    function automatic logic is_oob(input logic [31:0] a);
        return ({1'b0, a} + 33'd3) >= 33'(MEM_SIZE);
    endfunction

    function automatic logic is_mis(input logic [1:0] lo);
        return ALIGN_CHK && (lo != 2'b00);
    endfunction

    function automatic logic [AW-1:0] bidx(input logic [31:0] a, input int i);
        return AW'(a + 32'(i));
    endfunction

    logic [NP-1:0]       ln_en;
    logic [NP-1:0][31:0] ln_addr;
    logic [NP-1:0]       ln_oob;
    logic [NP-1:0]       ln_mis;
    logic [NP-1:0]       out_vld;
    logic [NP-1:0][31:0] out_dat;

    always_comb begin
        ln_en   = '0;
        ln_addr = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ln_en[k]   = rd_en[k];
            ln_addr[k] = rd_addr[32*k +: 32];
        end
        ln_en[NUM_RD]   = dm_rd & ~dm_wr;
        ln_addr[NUM_RD] = dm_addr;
    end

    for (genvar k = 0; k < NP; k++) begin : g_lane
        logic [L:1]       vld_pipe;
        logic [L:1][31:0] dat_pipe;
        logic [L:0]       vin;
        logic [L:0][31:0] din;
        logic [31:0]      word;

        always_comb begin
            word = '0;
            for (int i = 0; i < 4; i++)
                word[8*i +: 8] = mem[bidx(ln_addr[k], i)];
        end

        assign ln_oob[k] = ln_en[k] & is_oob(ln_addr[k]);
        assign ln_mis[k] = ln_en[k] & is_mis(ln_addr[k][1:0]);
        assign vin = {vld_pipe, ln_en[k]};
        assign din = {dat_pipe, ((ln_oob[k] | ln_mis[k]) ? 32'h0 : word)};

        // last stage only loads on a valid so the output holds between reads
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                vld_pipe <= '0;
                dat_pipe <= '0;
            end else begin
                vld_pipe <= vin[L-1:0];
                for (int s = 1; s <= L; s++)
                    if (s < L || vin[L-1]) dat_pipe[s] <= din[s-1];
            end
        end

        assign out_vld[k] = vin[L];
        assign out_dat[k] = din[L];
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_out
        assign rd_valid[k]         = out_vld[k];
        assign rd_data[32*k +: 32] = out_dat[k];
    end
    assign dm_rvalid = out_vld[NUM_RD];
    assign dm_rdata  = out_dat[NUM_RD];

    logic dm_wr_acc, wp_bad, dm_bad;
    logic new_conf, new_oob, new_mis;

    assign dm_wr_acc = dm_wr & ~dm_rd & (dm_be != 4'b0000);
    assign wp_bad    = is_oob(wp_addr) | is_mis(wp_addr[1:0]);
    assign dm_bad    = is_oob(dm_addr) | is_mis(dm_addr[1:0]);

    always_comb begin
        new_conf = dm_rd & dm_wr;
        new_oob  = (|ln_oob) | (wp_en & is_oob(wp_addr)) | (dm_wr_acc & is_oob(dm_addr));
        new_mis  = (|ln_mis) | (wp_en & is_mis(wp_addr[1:0])) | (dm_wr_acc & is_mis(dm_addr[1:0]));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_conflict <= 1'b0;
            err_oob      <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            err_conflict <= (err_conflict & ~err_clr) | new_conf;
            err_oob      <= (err_oob & ~err_clr) | new_oob;
            err_misalign <= (err_misalign & ~err_clr) | new_mis;
        end
    end

    // dm bytes are written after wp bytes, so dm wins on any overlap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // array contents intentionally survive reset
        end else begin
            if (wp_en && !wp_bad)
                for (int i = 0; i < 4; i++)
                    mem[bidx(wp_addr, i)] <= wp_data[8*i +: 8];
            if (dm_wr_acc && !dm_bad)
                for (int i = 0; i < 4; i++)
                    if (dm_be[i]) mem[bidx(dm_addr, i)] <= dm_wdata[8*i +: 8];
        end
    end

endmodule

// File: doc/multiport_mem_model.md
MULTIPORT_MEM_MODEL -- requirements
Module: multiport_mem_model

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 512, byte capacity of the little-endian byte array.
REQ-002 SHALL have parameter NUM_RD, default 3, number of independent word read ports (legal 1..4).
REQ-003 SHALL have parameter RD_LATENCY, default 1, cycles from read request to data (legal 1..4).
REQ-004 SHALL have ports clk in 1, the single clock, and reset_n in 1, asynchronous active-low reset.
REQ-005 SHALL have rd_en in NUM_RD and rd_addr in NUM_RD*32; port k uses rd_en[k] and rd_addr[32k+:32].
REQ-006 SHALL have rd_data out NUM_RD*32 and rd_valid out NUM_RD, the per-port read results.
REQ-007 SHALL have wp_en in 1, wp_addr in 32 and wp_data in 32, a full-word write port.
REQ-008 SHALL have dm_rd in 1, dm_wr in 1, dm_addr in 32, dm_wdata in 32 and dm_be in 4, the data-memory port.
REQ-009 SHALL have dm_rdata out 32 and dm_rvalid out 1, the data-port read result.
REQ-010 SHALL have err_conflict, err_oob and err_misalign, each out 1 and sticky, plus err_clr in 1.

Function
REQ-011 SHALL form each word as {mem[a+3],mem[a+2],mem[a+1],mem[a]} and write byte i of data to mem[a+i].
REQ-012 SHALL sample every request on the rising clk edge; no output is combinational from any input.
REQ-013 SHALL return read data RD_LATENCY cycles after the request edge, with the matching valid high for exactly one cycle.
REQ-014 SHALL accept a new request on every port every cycle (fully pipelined); rd_data and dm_rdata hold their last value while valid is low.
REQ-015 SHALL return pre-write contents for any read sampled on the same edge as a write to the same bytes (read-before-write).
REQ-016 SHALL write only the bytes whose dm_be bit is set on a dm_wr access; dm_be=0000 writes nothing and raises no error.
REQ-017 SHALL give the dm port priority when wp_en and dm_wr hit the same byte on the same edge; non-overlapping bytes from both ports are written.
REQ-018 SHALL perform no access when dm_rd and dm_wr are both high, set err_conflict, and keep dm_rvalid low for that request.
REQ-019 SHALL treat any access with a+3 >= MEM_SIZE as out of range: the read returns 32'h0 with valid high, the write is dropped, and err_oob is set.
REQ-020 SHALL clear all three error flags on err_clr; a new error on the same edge takes precedence and stays set.

Reset
REQ-021 SHALL, while reset_n is low, immediately force rd_data, dm_rdata, rd_valid, dm_rvalid and all error flags to 0.
REQ-022 SHALL discard in-flight read requests on reset; none produces a valid after release.
REQ-023 SHALL retain memory array contents across reset, with no write performed while reset_n is low.

Configuration
REQ-024 SHALL, with macro MULTIPORT_MEM_MODEL_ALIGN_CHECK_EN defined, treat any access with a[1:0]!=0 as misaligned: read returns 32'h0 with valid high, write is dropped, err_misalign is set.
REQ-025 SHALL, without the macro, service misaligned accesses byte-wise at a..a+3 and tie err_misalign to 0.

Verification
REQ-026 SHALL cover: wp writes 32'hDEADBEEF to address 8, then port 0 reads 8 -> rd_data[31:0]=DEADBEEF RD_LATENCY cycles later; mem[8]=EF, mem[11]=DE.
REQ-027 SHALL cover: on one edge, dm_wr to address 16 with data 11223344 and be=0101, while port 1 reads 16 (prior contents AABBCCDD) -> read returns AABBCCDD; next read of 16 returns AA22CC44.
REQ-028 SHALL cover: wp 00000000 and dm_wr FFFFFFFF with be=0011 both to address 4 on one edge -> word 4 = 0000FFFF.
REQ-029 SHALL cover: dm_rd=dm_wr=1 -> memory unchanged, dm_rvalid stays 0, err_conflict=1 until err_clr.
REQ-030 SHALL cover: read at MEM_SIZE-2 -> data 0, valid 1, err_oob=1; misaligned read at 6 -> err_misalign=1 with the macro, bytes 6..9 without it.
REQ-031 SHALL cover: with RD_LATENCY=3, assert reset_n low one cycle after a read request -> outputs 0 immediately, no rd_valid after release, memory unchanged.
